// File: rtl/conv_dot_pipe.sv
// rtl/conv_dot_pipe.sv - pipelined multi-channel dot-product engine with per-beat weight snapshot
// Beats enter S0, flow through product/partial/final-sum stages, and leave through a stallable output register.
module conv_dot_pipe #(
  parameter int DW     = 4,
  parameter int CH     = 2,
  parameter int K      = 16,
  parameter int SIGNED = 0,
  localparam int OW    = 2*DW + $clog2(CH*K)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CH*K*DW-1:0] in_ifm,
  input  logic               weight_valid,
  input  logic [CH*K*DW-1:0] in_weight,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OW-1:0]      out_ofm
);

  localparam int N  = CH*K;
  localparam int PW = 2*DW;
  localparam int EW = OW - PW;

  logic [N*DW-1:0] w_q;
  logic [N*DW-1:0] ifm_s0;
  logic [N*DW-1:0] wt_s0;
  logic            v0;
  logic            v1;
  logic            v2;
  logic            v3;
  logic [PW-1:0]   prod_d [N];
  logic [PW-1:0]   prod_q [N];
  logic [OW-1:0]   part_d [CH];
  logic [OW-1:0]   part_q [CH];
  logic [OW-1:0]   sum_d;
  logic [OW-1:0]   sum_q;
  logic            stall;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // Extending both operands to 2*DW first makes the low 2*DW bits of the product
  // correct for either signedness, so one multiplier shape serves both modes.
  function automatic logic [PW-1:0] mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [PW-1:0] ax;
    logic [PW-1:0] bx;
    if (SIGNED != 0) begin
      ax = {{DW{a[DW-1]}}, a};
      bx = {{DW{b[DW-1]}}, b};
    end else begin
      ax = {{DW{1'b0}}, a};
      bx = {{DW{1'b0}}, b};
    end
    return ax * bx;
  endfunction

  function automatic logic [OW-1:0] widen(input logic [PW-1:0] p);
    if (SIGNED != 0) return {{EW{p[PW-1]}}, p};
    else             return {{EW{1'b0}}, p};
  endfunction

  always_comb begin
    for (int i = 0; i < N; i++) begin
      prod_d[i] = mul(ifm_s0[i*DW +: DW], wt_s0[i*DW +: DW]);
    end
  end

  always_comb begin
    for (int c = 0; c < CH; c++) begin
      part_d[c] = '0;
      for (int e = 0; e < K; e++) begin
        part_d[c] = part_d[c] + widen(prod_q[c*K + e]);
      end
    end
  end

  always_comb begin
    sum_d = '0;
    for (int c = 0; c < CH; c++) begin
      sum_d = sum_d + part_q[c];
    end
  end

  // Weight register follows weight_valid regardless of stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q <= '0;
    end else if (weight_valid) begin
      w_q <= in_weight;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0        <= 1'b0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      ifm_s0    <= '0;
      wt_s0     <= '0;
      sum_q     <= '0;
      out_valid <= 1'b0;
      out_ofm   <= '0;
      for (int i = 0; i < N; i++) prod_q[i] <= '0;
      for (int c = 0; c < CH; c++) part_q[c] <= '0;
    end else if (!stall) begin
      // Snapshot the weights that apply to this beat, including a same-cycle update.
      v0     <= in_valid;
      ifm_s0 <= in_valid ? in_ifm : '0;
      wt_s0  <= in_valid ? (weight_valid ? in_weight : w_q) : '0;

      v1 <= v0;
      for (int i = 0; i < N; i++) prod_q[i] <= v0 ? prod_d[i] : '0;

      v2 <= v1;
      for (int c = 0; c < CH; c++) part_q[c] <= v1 ? part_d[c] : '0;

      v3    <= v2;
      sum_q <= v2 ? sum_d : '0;

      out_valid <= v3;
      out_ofm   <= v3 ? sum_q : '0;
    end
  end

endmodule
